// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches from a variable-latency imem and drives the IF/ID register.
// Build option IFID_FLUSH_EN: taken branches flush IF/ID; without it, MIPS delay-slot semantics.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPC4,
  output logic        IFIDValid
);
  typedef enum logic [1:0] {REQ = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};

  state_t      state;
  ifid_t       ifid;
  logic [31:0] pc, pc4, next_pc, hold_instr;
  logic        advance, redirect;

  assign advance   = PCWrite & IFIDWrite;
  // A branch seen while the PC is frozen is still unresolved upstream.
  assign redirect  = branchTaken & PCWrite;
  assign pc4       = pc + 32'd4;
  assign imemReq   = ~rst & (state != HOLD);
  assign IFIDInstr = ifid.instr;
  assign IFIDPC4   = ifid.pc4;
  assign IFIDValid = ifid.valid;

`ifdef IFID_FLUSH_EN
  // Address of the abandoned request; must stay on the bus until its response drains.
  logic [31:0] drain_addr;

  assign next_pc  = pc4;
  assign imemAddr = (state == DRAIN) ? drain_addr : pc;
`else
  logic        pend_vld, slot_fire, tgt_vld;
  logic [31:0] pend_tgt;

  // The delay-slot instruction leaves IF this cycle; the branch may resolve in the same cycle.
  assign slot_fire = advance & (((state == REQ) & imemReady) | (state == HOLD));
  assign tgt_vld   = pend_vld | redirect;
  assign next_pc   = tgt_vld ? (redirect ? branchTarget : pend_tgt) : pc4;
  assign imemAddr  = pc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      ifid       <= BUBBLE;
      hold_instr <= NOP_INSTR;
`ifdef IFID_FLUSH_EN
      drain_addr <= RESET_PC;
`else
      pend_vld   <= 1'b0;
      pend_tgt   <= 32'd0;
`endif
    end else begin
      case (state)
        REQ: begin
`ifdef IFID_FLUSH_EN
          if (redirect) begin
            pc   <= branchTarget;
            ifid <= BUBBLE;
            if (!imemReady) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end
          end else
`endif
          if (imemReady) begin
            if (advance) begin
              ifid <= '{pc4: pc4, instr: imemData, valid: 1'b1};
              pc   <= next_pc;
            end else begin
              hold_instr <= imemData;
              state      <= HOLD;
            end
          end else if (IFIDWrite) begin
            ifid <= BUBBLE;
          end
        end
        HOLD: begin
`ifdef IFID_FLUSH_EN
          if (redirect) begin
            pc    <= branchTarget;
            ifid  <= BUBBLE;
            state <= REQ;
          end else
`endif
          if (advance) begin
            ifid  <= '{pc4: pc4, instr: hold_instr, valid: 1'b1};
            pc    <= next_pc;
            state <= REQ;
          end
        end
`ifdef IFID_FLUSH_EN
        DRAIN: begin
          if (redirect)  pc    <= branchTarget;
          if (IFIDWrite) ifid  <= BUBBLE;
          if (imemReady) state <= REQ;
        end
`endif
        default: state <= REQ;
      endcase
`ifndef IFID_FLUSH_EN
      if (slot_fire) begin
        pend_vld <= 1'b0;
      end else if (redirect) begin
        pend_vld <= 1'b1;
        pend_tgt <= branchTarget;
      end
`endif
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized stalls/latency against a fetch-stream model.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk, rst, PCWrite, IFIDWrite, branchTaken, imemReq, imemReady, IFIDValid;
  logic [31:0] branchTarget, imemAddr, imemData, IFIDInstr, IFIDPC4;
  int          checks = 0;
  int          errors = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
    .IFIDInstr(IFIDInstr), .IFIDPC4(IFIDPC4), .IFIDValid(IFIDValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One clock: drive at the falling edge, return just after the rising edge.
  task automatic cyc(input logic pw, input logic iw, input logic rdy, input logic [31:0] d,
                     input logic bt, input logic [31:0] tgt);
    @(negedge clk);
    PCWrite = pw; IFIDWrite = iw; imemReady = rdy; imemData = d;
    branchTaken = bt; branchTarget = tgt;
    @(posedge clk); #1;
    imemReady = 1'b0; branchTaken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; imemReady = 1'b0; imemData = 32'd0;
    branchTaken = 1'b0; branchTarget = 32'd0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; imemReady = 1'b0; imemData = 32'd0;
    branchTaken = 1'b0; branchTarget = 32'd0;
    #2;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imemReq); end
    checks++; if (IFIDValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", IFIDValid); end
    checks++; if (IFIDInstr !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", IFIDInstr, NOP); end
    checks++; if (IFIDPC4 !== 32'd0) begin errors++; $display("FAIL rst_pc4: got %h want 0", IFIDPC4); end
    @(posedge clk); #1;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL rst_req_hold: got %b want 0", imemReq); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imemReq); end
    checks++; if (imemAddr !== 32'd0) begin errors++; $display("FAIL first_addr: got %h want 0", imemAddr); end
    @(posedge clk); #1;
    checks++; if (IFIDValid !== 1'b0) begin errors++; $display("FAIL first_bubble: got %b want 0", IFIDValid); end
    checks++; if (imemAddr !== 32'd0) begin errors++; $display("FAIL first_addr_stable: got %h want 0", imemAddr); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
      checks++; if (IFIDPC4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL zw_pc4[%0d]: got %h want %h", i, IFIDPC4, 32'(4 * (i + 1))); end
      checks++; if (IFIDInstr !== 32'(4 * i)) begin errors++; $display("FAIL zw_instr[%0d]: got %h want %h", i, IFIDInstr, 32'(4 * i)); end
      checks++; if (IFIDValid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b want 1", i, IFIDValid); end
    end
  endtask

  task automatic test_load_use();
    cyc(1'b0, 1'b0, 1'b1, 32'h8C01_0004, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'd24) begin errors++; $display("FAIL lu_hold_pc4: got %h want 18", IFIDPC4); end
    checks++; if (IFIDInstr !== 32'd20) begin errors++; $display("FAIL lu_hold_instr: got %h want 14", IFIDInstr); end
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL lu_hold_req: got %b want 0", imemReq); end
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (IFIDInstr !== 32'h8C01_0004) begin errors++; $display("FAIL lu_instr: got %h want 8c010004", IFIDInstr); end
    checks++; if (IFIDPC4 !== 32'd28) begin errors++; $display("FAIL lu_pc4: got %h want 1c", IFIDPC4); end
    checks++; if (IFIDValid !== 1'b1) begin errors++; $display("FAIL lu_valid: got %b want 1", IFIDValid); end
    checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL lu_req: got %b want 1", imemReq); end
    checks++; if (imemAddr !== 32'd28) begin errors++; $display("FAIL lu_addr: got %h want 1c", imemAddr); end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      checks++; if (IFIDValid !== 1'b0) begin errors++; $display("FAIL mw_valid[%0d]: got %b want 0", i, IFIDValid); end
      checks++; if (IFIDInstr !== NOP) begin errors++; $display("FAIL mw_instr[%0d]: got %h want %h", i, IFIDInstr, NOP); end
      checks++; if (IFIDPC4 !== 32'd0) begin errors++; $display("FAIL mw_pc4[%0d]: got %h want 0", i, IFIDPC4); end
      checks++; if (imemAddr !== 32'd28 || imemReq !== 1'b1) begin errors++; $display("FAIL mw_addr[%0d]: got %h/%b want 1c/1", i, imemAddr, imemReq); end
    end
    cyc(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'd32 || IFIDInstr !== 32'h1234_5678) begin errors++; $display("FAIL mw_resume: got %h/%h want 20/12345678", IFIDPC4, IFIDInstr); end
  endtask

  task automatic test_branch_stall();
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
    checks++; if (imemAddr !== 32'd32) begin errors++; $display("FAIL bs_addr: got %h want 20", imemAddr); end
    checks++; if (IFIDPC4 !== 32'd32) begin errors++; $display("FAIL bs_ifid: got %h want 20", IFIDPC4); end
    cyc(1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'd36 || imemAddr !== 32'd36) begin errors++; $display("FAIL bs_seq1: got %h/%h want 24/24", IFIDPC4, imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, 32'hAAAA_0002, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'd40 || imemAddr !== 32'd40) begin errors++; $display("FAIL bs_seq2: got %h/%h want 28/28", IFIDPC4, imemAddr); end
  endtask

`ifndef IFID_FLUSH_EN
  task automatic test_delay_slot();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (imemAddr !== 32'h20) begin errors++; $display("FAIL ds_setup: got %h want 20", imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h100);
    checks++; if (IFIDPC4 !== 32'h24 || IFIDInstr !== 32'h20 || IFIDValid !== 1'b1) begin errors++; $display("FAIL ds_slot: got %h/%h/%b want 24/20/1", IFIDPC4, IFIDInstr, IFIDValid); end
    checks++; if (imemAddr !== 32'h100) begin errors++; $display("FAIL ds_target: got %h want 100", imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'h104 || IFIDInstr !== 32'h100) begin errors++; $display("FAIL ds_tgt_instr: got %h/%h want 104/100", IFIDPC4, IFIDInstr); end
    // Branch resolves while the slot fetch is still waiting on memory.
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h200);
    checks++; if (imemAddr !== 32'h104 || IFIDValid !== 1'b0) begin errors++; $display("FAIL ds_wait: got %h/%b want 104/0", imemAddr, IFIDValid); end
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'h108 || IFIDInstr !== 32'h104) begin errors++; $display("FAIL ds_late_slot: got %h/%h want 108/104", IFIDPC4, IFIDInstr); end
    checks++; if (imemAddr !== 32'h200) begin errors++; $display("FAIL ds_late_target: got %h want 200", imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b1, 32'hFFFF_FFF8);
    checks++; if (imemAddr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL ds_hi_target: got %h want fffffff8", imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'hFFFF_FFFC || imemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre: got %h/%h want fffffffc/fffffffc", IFIDPC4, imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'd0 || IFIDInstr !== 32'hFFFF_FFFC || imemAddr !== 32'd0) begin errors++; $display("FAIL wrap: got %h/%h/%h want 0/fffffffc/0", IFIDPC4, IFIDInstr, imemAddr); end
  endtask
`else
  task automatic test_flush();
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'd4 || imemAddr !== 32'd4) begin errors++; $display("FAIL fl_setup: got %h/%h want 4/4", IFIDPC4, imemAddr); end
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h100);
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'd4) begin errors++; $display("FAIL fl_drain_addr: got %b/%h want 1/4", imemReq, imemAddr); end
    checks++; if (IFIDValid !== 1'b0) begin errors++; $display("FAIL fl_bubble: got %b want 0", IFIDValid); end
    cyc(1'b1, 1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'd0);
    checks++; if (IFIDValid !== 1'b0 || IFIDInstr !== NOP) begin errors++; $display("FAIL fl_discard: got %b/%h want 0/%h", IFIDValid, IFIDInstr, NOP); end
    checks++; if (imemAddr !== 32'h100) begin errors++; $display("FAIL fl_target: got %h want 100", imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'h104 || IFIDInstr !== 32'h100) begin errors++; $display("FAIL fl_tgt_instr: got %h/%h want 104/100", IFIDPC4, IFIDInstr); end
    cyc(1'b1, 1'b1, 1'b1, 32'hBAD1_BAD1, 1'b1, 32'hFFFF_FFF8);
    checks++; if (IFIDValid !== 1'b0 || imemAddr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL fl_ready_flush: got %b/%h want 0/fffffff8", IFIDValid, imemAddr); end
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, imemAddr, 1'b0, 32'd0);
    checks++; if (IFIDPC4 !== 32'd0 || IFIDInstr !== 32'hFFFF_FFFC || imemAddr !== 32'd0) begin errors++; $display("FAIL wrap: got %h/%h/%h want 0/fffffffc/0", IFIDPC4, IFIDInstr, imemAddr); end
  endtask
`endif

  // Fetch stream model: each delivered instruction is the next word in program order,
  // at most one fetched word waits for the pipeline, and nothing else touches IF/ID.
  task automatic test_random();
    logic [31:0] exp_pc, m_pc4, m_ins;
    logic        m_v, held, pw, iw, rdy;
    int          wait_cnt;
    do_reset();
    exp_pc = 32'd0; m_pc4 = 32'd0; m_ins = NOP; m_v = 1'b0; held = 1'b0; wait_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      checks++; if (imemReq !== !held) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", n, imemReq, !held); end
      if (!held) begin
        checks++; if (imemAddr !== exp_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, imemAddr, exp_pc); end
      end
      pw  = ($urandom_range(0, 3) != 0);
      iw  = ($urandom_range(0, 3) != 0);
      rdy = 1'b0;
      if (imemReq) begin
        if (wait_cnt == 0) begin
          rdy = 1'b1;
          wait_cnt = $urandom_range(0, 2);
        end else begin
          wait_cnt--;
        end
      end
      PCWrite = pw; IFIDWrite = iw; imemReady = rdy;
      imemData = rdy ? mem(imemAddr) : $urandom;
      if (held || rdy) begin
        if (pw && iw) begin
          m_pc4 = exp_pc + 32'd4; m_ins = mem(exp_pc); m_v = 1'b1;
          exp_pc = exp_pc + 32'd4; held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end else if (iw) begin
        m_pc4 = 32'd0; m_ins = NOP; m_v = 1'b0;
      end
      @(posedge clk); #1;
      checks++; if (IFIDPC4 !== m_pc4) begin errors++; $display("FAIL rnd_pc4[%0d]: got %h want %h", n, IFIDPC4, m_pc4); end
      checks++; if (IFIDInstr !== m_ins) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", n, IFIDInstr, m_ins); end
      checks++; if (IFIDValid !== m_v) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, IFIDValid, m_v); end
    end
    imemReady = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1;
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b1, 1'b1, 32'h7777_0000, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b want 0", imemReq); end
    checks++; if (IFIDValid !== 1'b0 || IFIDPC4 !== 32'd0 || IFIDInstr !== NOP) begin errors++; $display("FAIL mid_rst_ifid: got %b/%h/%h want 0/0/%h", IFIDValid, IFIDPC4, IFIDInstr, NOP); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin errors++; $display("FAIL mid_rst_restart: got %b/%h want 1/0", imemReq, imemAddr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_load_use();
    test_mem_wait();
    test_branch_stall();
`ifndef IFID_FLUSH_EN
    test_delay_slot();
`else
    test_flush();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It is the consumer of the hazard checker's `PCWrite`/`IFIDWrite` stall outputs and of the ID-stage branch decision. It owns the PC, issues requests to a variable-latency instruction memory, and parks a returned instruction in a one-entry hold register while the pipeline is stalled. It inserts bubbles on memory wait, and redirects or flushes on taken `beq`.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded by reset.
- `NOP_INSTR`, default 32'h0000_0000, encoding driven into IF/ID for bubbles.

- `clk` in 1: core clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `PCWrite` in 1: from hazard checker; 0 = freeze PC.
- `IFIDWrite` in 1: from hazard checker; 0 = freeze IF/ID.
- `branchTaken` in 1: taken `beq` resolved in ID this cycle.
- `branchTarget` in 32: target address, valid with `branchTaken`.
- `imemReq` out 1: fetch request.
- `imemAddr` out 32: fetch address, word aligned.
- `imemReady` in 1: response strobe; one-cycle pulse.
- `imemData` in 32: instruction, valid with `imemReady`.
- `IFIDInstr` out 32: registered instruction to ID.
- `IFIDPC4` out 32: registered PC+4 of that instruction.
- `IFIDValid` out 1: 0 = bubble.

## Operation
- States:
  - REQ: request outstanding; `imemReq`=1, `imemAddr`=pc.
  - HOLD: instruction parked; `imemReq`=0.
  - DRAIN: discard the in-flight response; `imemReq`=1, address unchanged.
- `advance` = `PCWrite` & `IFIDWrite`.
- REQ, `imemReady`=1:
  - If `advance`: IF/ID <= {pc+4, `imemData`, 1}; pc <= pc+4; stay in REQ.
  - Else: hold <= `imemData`; go to HOLD.
- REQ, `imemReady`=0: if `IFIDWrite`, IF/ID <= bubble {0, `NOP_INSTR`, 0}; otherwise IF/ID holds.
- HOLD:
  - If `advance`: IF/ID <= hold entry; pc <= pc+4; go to REQ.
  - Else: all registers hold.
- `imemAddr` and `imemReq` stay stable from assertion until `imemReady`. A request is never withdrawn.
- `branchTaken` is honoured only when `PCWrite`=1. The hazard checker stalls an unresolved `beq` in ID, so `branchTaken` with `PCWrite`=0 is ignored.
- Redirect, with `IFID_FLUSH_EN`:
  - pc <= `branchTarget`.
  - IF/ID <= bubble.
  - The hold entry is dropped.
  - If REQ and `imemReady`=0, go to DRAIN; else go to REQ.
- DRAIN: on `imemReady`, discard the data and go to REQ at the new pc. A second `branchTaken` in DRAIN only updates pc.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: pc=`RESET_PC`, state=REQ, `IFIDInstr`=`NOP_INSTR`, `IFIDPC4`=0, `IFIDValid`=0, hold empty, pending target clear. `imemReq`=0 while `rst`=1.
- First request: `imemReq`=1 with `imemAddr`=`RESET_PC` in the first cycle after `rst` falls.
- Latency: the instruction appears on IF/ID outputs at the edge that samples `imemReady`. With `imemReady` tied high, throughput is one instruction per cycle.
- HOLD to IF/ID: one edge after `advance` returns.
- Redirect: the target address appears on `imemAddr` in the cycle after `branchTaken`, or after DRAIN completes.
- `rst` asserted mid-transaction: all state returns to reset values immediately. The memory must also be reset, so no stale `imemReady` is expected.

## Configuration
- `IFID_FLUSH_EN` defined: a taken branch flushes the fetched slot, as described in Operation. There is no delay slot.
- `IFID_FLUSH_EN` undefined: MIPS branch-delay-slot semantics.
  - The instruction at the current pc (branch+4) completes its fetch and enters IF/ID normally.
  - `branchTarget` is latched into a pending-target register.
  - When that slot instruction advances, pc <= pending target instead of pc+4.
  - No bubble is inserted and DRAIN is unused.

## Test plan
- Zero-wait fetch: reset with `RESET_PC`=0x0, `imemReady`=1, `imemData`=addr. IF/ID shows PC4=4,8,12,… on consecutive cycles with `IFIDValid`=1.
- Load-use stall: `PCWrite`=`IFIDWrite`=0 for 1 cycle while `imemReady`=1 with 0x8C01_0004. The instruction goes to HOLD, IF/ID is unchanged, `imemReq`=0, and 0x8C01_0004 enters IF/ID one edge after the stall drops.
- Memory wait: `imemReady` low for 3 cycles. IF/ID shows 3 bubbles (`IFIDValid`=0, `NOP_INSTR`) and `imemAddr` is stable across all 3.
- Flush branch (`IFID_FLUSH_EN`): `branchTaken`=1 with target 0x100 while a request is outstanding. The state passes through DRAIN, the old response is discarded, the next `imemAddr`=0x100, and IF/ID gets a bubble.
- Delay slot (no `IFID_FLUSH_EN`): `branchTaken` to 0x100 at pc=0x20. Instruction 0x20 enters IF/ID, then `imemAddr`=0x100.
- Branch during stall: `branchTaken`=1 with `PCWrite`=0. pc is unchanged and no redirect occurs.
